// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, top-level one-hot states and
// default bus widths used by the arbiter and the init/aref/write/read engines.
package sdram_pkg;

  localparam int DQ_W_DEF   = 16;
  localparam int ADDR_W_DEF = 13;
  localparam int BANK_W_DEF = 2;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_ARBIT = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } state_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Selects the bus of the engine owning the current state and registers the
// whole SDRAM command/address/data group in one stage so they stay aligned.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int DQ_W   = DQ_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BANK_W = BANK_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  state_t            state,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe
);

  logic [3:0]        cmd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [BANK_W-1:0] bank_d;
  logic [DQ_W-1:0]   dq_d;
  logic              oe_d;

  // ARBIT and any corrupt encoding park the bus on NOP
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    bank_d = '0;
    dq_d   = '0;
    oe_d   = 1'b0;
    case (state)
      ST_INIT:  begin cmd_d = init_cmd; addr_d = init_addr; end
      ST_AREF:  begin cmd_d = aref_cmd; addr_d = aref_addr; end
      ST_WRITE: begin
        cmd_d  = wr_cmd;
        addr_d = wr_addr;
        bank_d = wr_bank;
        dq_d   = wr_data;
        oe_d   = 1'b1;
      end
      ST_READ:  begin cmd_d = rd_cmd; addr_d = rd_addr; bank_d = rd_bank; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdram_cmd    <= CMD_NOP;
      sdram_addr   <= '0;
      sdram_bank   <= '0;
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      sdram_cmd    <= cmd_d;
      sdram_addr   <= addr_d;
      sdram_bank   <= bank_d;
      sdram_dq_out <= dq_d;
      sdram_dq_oe  <= oe_d;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM arbiter: init handoff, fixed-priority grant (refresh > write > read)
// with no preemption, and the registered command bus to the device.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int DQ_W   = DQ_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BANK_W = BANK_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic              sdram_cke
);

  state_t state, state_d;

  assign sdram_cke = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_INIT:  if (init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if      (aref_req) state_d = ST_AREF;
        else if (wr_req)   state_d = ST_WRITE;
        else if (rd_req)   state_d = ST_READ;
      end
      ST_AREF:  if (aref_end) state_d = ST_ARBIT;
      ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
      ST_READ:  if (rd_end)   state_d = ST_ARBIT;
      default:  state_d = ST_ARBIT;
    endcase
  end

  // grants are registered alongside the state so they mark its first cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      aref_en <= (state == ST_ARBIT) && (state_d == ST_AREF);
      wr_en   <= (state == ST_ARBIT) && (state_d == ST_WRITE);
      rd_en   <= (state == ST_ARBIT) && (state_d == ST_READ);
    end
  end

  sdram_cmd_mux #(.DQ_W(DQ_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) u_mux (
    .clk          (clk),
    .rst_n        (rst_n),
    .state        (state),
    .init_cmd     (init_cmd),
    .init_addr    (init_addr),
    .aref_cmd     (aref_cmd),
    .aref_addr    (aref_addr),
    .wr_cmd       (wr_cmd),
    .wr_addr      (wr_addr),
    .wr_bank      (wr_bank),
    .wr_data      (wr_data),
    .rd_cmd       (rd_cmd),
    .rd_addr      (rd_addr),
    .rd_bank      (rd_bank),
    .sdram_cmd    (sdram_cmd),
    .sdram_addr   (sdram_addr),
    .sdram_bank   (sdram_bank),
    .sdram_dq_out (sdram_dq_out),
    .sdram_dq_oe  (sdram_dq_oe)
  );

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: cycle model of the owner/grant rules compared every
// negedge, plus directed literal checks along the scripted scenario.
module tb_sdram_arbit;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = CMD_PRE;
  logic [12:0] init_addr = 13'h0400;
  logic        aref_req = 1'b0, aref_end = 1'b0;
  logic [3:0]  aref_cmd = CMD_AREF;
  logic [12:0] aref_addr = 13'h0011;
  logic        wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]  wr_cmd = CMD_ACT;
  logic [12:0] wr_addr = 13'h0055;
  logic [1:0]  wr_bank = 2'd1;
  logic [15:0] wr_data = 16'h0000;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = CMD_RD;
  logic [12:0] rd_addr = 13'h0022;
  logic [1:0]  rd_bank = 2'd2;
  logic        aref_en, wr_en, rd_en;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe, sdram_cke;

  int tests = 0;
  int fails = 0;

  sdram_arbit dut (
    .clk(clk), .rst_n(rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .wr_bank(wr_bank), .wr_data(wr_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .sdram_cke(sdram_cke)
  );

  always #5 clk = ~clk;

  // Model: who owns the bus, and what the registered bus/grant must show.
  localparam int M_INIT = 0, M_ARBIT = 1, M_AREF = 2, M_WRITE = 3, M_READ = 4;
  int          owner;
  logic [2:0]  e_en;   // {aref, wr, rd}
  logic [3:0]  e_cmd;
  logic [12:0] e_addr;
  logic [1:0]  e_bank;
  logic [15:0] e_dq;
  logic        e_oe;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= M_INIT; e_en <= 3'b000; e_cmd <= CMD_NOP;
      e_addr <= '0; e_bank <= '0; e_dq <= '0; e_oe <= 1'b0;
    end else begin
      e_en <= 3'b000; e_cmd <= CMD_NOP; e_addr <= '0; e_bank <= '0; e_dq <= '0; e_oe <= 1'b0;
      case (owner)
        M_INIT: begin
          e_cmd <= init_cmd; e_addr <= init_addr;
          if (init_end) owner <= M_ARBIT;
        end
        M_ARBIT: begin
          if (aref_req)    begin owner <= M_AREF;  e_en <= 3'b100; end
          else if (wr_req) begin owner <= M_WRITE; e_en <= 3'b010; end
          else if (rd_req) begin owner <= M_READ;  e_en <= 3'b001; end
        end
        M_AREF: begin
          e_cmd <= aref_cmd; e_addr <= aref_addr;
          if (aref_end) owner <= M_ARBIT;
        end
        M_WRITE: begin
          e_cmd <= wr_cmd; e_addr <= wr_addr; e_bank <= wr_bank; e_dq <= wr_data; e_oe <= 1'b1;
          if (wr_end) owner <= M_ARBIT;
        end
        default: begin
          e_cmd <= rd_cmd; e_addr <= rd_addr; e_bank <= rd_bank;
          if (rd_end) owner <= M_ARBIT;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [39:0] act, exp;
    act = {aref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe, sdram_cke};
    exp = {e_en, e_cmd, e_addr, e_bank, e_dq, e_oe, 1'b1};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act, exp);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    chk("rst_cmd", 32'(sdram_cmd), 32'h7);
    chk("rst_cke", 32'(sdram_cke), 32'h1);
    chk("rst_oe", 32'(sdram_dq_oe), 32'h0);
    rst_n = 1'b1;
    step();
    chk("init_cmd", 32'(sdram_cmd), 32'(CMD_PRE));
    chk("init_addr", 32'(sdram_addr), 32'h400);
    for (int i = 0; i < 18; i++) step();
    init_end = 1'b1;
    step();
    chk("init_last_cmd", 32'(sdram_cmd), 32'(CMD_PRE));
    step();
    chk("arbit_nop", 32'(sdram_cmd), 32'(CMD_NOP));

    // all three requesters at once: refresh wins
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step();
    chk("prio_grants", {29'd0, aref_en, wr_en, rd_en}, 32'b100);
    step();
    chk("aref_pulse_len", 32'(aref_en), 32'h0);
    chk("aref_cmd", 32'(sdram_cmd), 32'(CMD_AREF));
    aref_req = 1'b0; aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    chk("no_wr_yet", 32'(wr_en), 32'h0);
    step();
    chk("wr_grant", {29'd0, aref_en, wr_en, rd_en}, 32'b010);
    chk("wr_grant_nop", 32'(sdram_cmd), 32'(CMD_NOP));

    // write burst: ACT then WR with aligned data
    step();
    chk("wr_act", 32'(sdram_cmd), 32'(CMD_ACT));
    chk("wr_oe", 32'(sdram_dq_oe), 32'h1);
    wr_cmd = CMD_WR; wr_data = 16'h00A5;
    step();
    chk("wr_cmd", 32'(sdram_cmd), 32'(CMD_WR));
    chk("wr_dq", 32'(sdram_dq_out), 32'h00A5);
    chk("wr_bank", 32'(sdram_bank), 32'h1);
    wr_cmd = CMD_NOP; rd_end = 1'b1; aref_req = 1'b1;
    step();
    rd_end = 1'b0;
    chk("no_preempt", 32'(aref_en), 32'h0);
    step();
    chk("rd_end_ignored", 32'(sdram_dq_oe), 32'h1);
    wr_cmd = CMD_PRE; wr_end = 1'b1; wr_req = 1'b0;
    step();
    wr_end = 1'b0;
    chk("wr_pre", 32'(sdram_cmd), 32'(CMD_PRE));
    chk("aref_wait", 32'(aref_en), 32'h0);
    step();
    chk("aref_after_wr", 32'(aref_en), 32'h1);
    chk("aref_gap_oe", 32'(sdram_dq_oe), 32'h0);
    chk("aref_gap_nop", 32'(sdram_cmd), 32'(CMD_NOP));
    aref_req = 1'b0; aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    step();
    chk("rd_grant", {29'd0, aref_en, wr_en, rd_en}, 32'b001);
    step();
    chk("rd_cmd", 32'(sdram_cmd), 32'(CMD_RD));
    chk("rd_bank", 32'(sdram_bank), 32'h2);
    chk("rd_addr", 32'(sdram_addr), 32'h22);

    // reset in the middle of a read burst
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", 32'(sdram_cmd), 32'(CMD_NOP));
    chk("mid_rst_bus", {sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe}, 32'h0);
    rd_req = 1'b0; init_end = 1'b0;
    step();
    chk("mid_rst_en", {29'd0, aref_en, wr_en, rd_en}, 32'b000);
    rst_n = 1'b1;
    step();
    chk("reinit_cmd", 32'(sdram_cmd), 32'(CMD_PRE));
    step(); step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
